// File: rtl/pixel_mem_arbiter_pkg.sv
// pixel_mem_pkg: shared constants and types for the pixel memory arbiter.
//   PIXELS_TOTAL  number of valid pixel byte addresses (5 banks x BANK_DEPTH)
//   BANK_DEPTH    bytes per memory bank
//   ADDR_W        pixel byte address width
//   stateT        arbiter FSM states
//   grantT        identity of the most recently granted requester
package pixel_mem_pkg;

   localparam int ADDR_W       = 20;
   localparam int BANK_DEPTH   = 65000;
   localparam int NUM_BANKS    = 5;
   localparam int PIXELS_TOTAL = BANK_DEPTH * NUM_BANKS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      BURST  = 2'd2
   } stateT;

   typedef enum logic {
      GNT_CPU  = 1'b0,
      GNT_STRM = 1'b1
   } grantT;

endpackage

// File: rtl/pixel_mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter (CPU vs. pixel streamer).
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       arbiter may accept a request this cycle
//   reqCpu       CPU request valid
//   reqStrm      streamer request valid
//   update       a request is accepted this cycle; record the winner
//   readyCpu     CPU may be accepted this cycle
//   readyStrm    streamer may be accepted this cycle
// A ready only drops for the loser of a tie; a lone requester always sees
// ready while enabled. The last-grant register starts at GNT_STRM so the
// CPU wins the first tie after reset.
module rr_arb2
   import pixel_mem_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic reqCpu,
   input  logic reqStrm,
   input  logic update,
   output logic readyCpu,
   output logic readyStrm
);

   grantT lastGrant;
   logic  tie;
   logic  preferCpu;

   assign tie       = reqCpu && reqStrm;
   assign preferCpu = (lastGrant == GNT_STRM);
   assign readyCpu  = enable && !(tie && !preferCpu);
   assign readyStrm = enable && !(tie && preferCpu);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant <= GNT_STRM;
      end else if (update) begin
         lastGrant <= (reqCpu && readyCpu) ? GNT_CPU : GNT_STRM;
      end
   end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: shares the read-only pixel memory between the CPU load
// path (single reads) and the pixel streamer (bursts of len+1 pixels).
//   cpu_req_*    CPU read request (valid/ready), 20-bit byte address
//   cpu_rsp_*    one-cycle response pulse, zero-extended pixel, error flag
//   strm_req_*   burst request (valid/ready): first address, beats minus one
//   strm_rsp_*   beat stream (valid/ready) with pixel, error flag and last
//   mem_addr     address to the data memory, decoded from state
//   mem_rdata    combinational memory data, pixel in bits 7:0
//   busy         arbiter is serving a transaction
//   dbgState     current FSM state for observation
// Handshakes: a request transfers on a rising edge where valid && ready;
// requesters hold valid and payload until that edge. A stream beat transfers
// where strm_rsp_valid && strm_rsp_ready and is held stable until then. The
// CPU response has no backpressure. Addresses >= PIXELS_TOTAL are never read:
// they return data 0 with the error flag set.
module pixel_mem_arbiter #(
   parameter int PIXELS_TOTAL = pixel_mem_pkg::PIXELS_TOTAL,
   parameter int LEN_W        = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_req_valid,
   input  logic [19:0]          cpu_req_addr,
   output logic                 cpu_req_ready,
   output logic                 cpu_rsp_valid,
   output logic [31:0]          cpu_rsp_data,
   output logic                 cpu_rsp_err,
   input  logic                 strm_req_valid,
   input  logic [19:0]          strm_req_addr,
   input  logic [LEN_W-1:0]     strm_req_len,
   output logic                 strm_req_ready,
   output logic                 strm_rsp_valid,
   input  logic                 strm_rsp_ready,
   output logic [7:0]           strm_rsp_data,
   output logic                 strm_rsp_err,
   output logic                 strm_rsp_last,
   output logic [19:0]          mem_addr,
   input  logic [31:0]          mem_rdata,
   output logic                 busy,
   output pixel_mem_pkg::stateT dbgState
);

   import pixel_mem_pkg::*;

   stateT            state;
   logic [19:0]      addrQ;
   logic [19:0]      burstAddr;
   logic [LEN_W-1:0] beatCnt;

   logic             idle;
   logic             cpuAcc;
   logic             strmAcc;
   logic             issue;
   logic             rdErr;
   logic [7:0]       rdPixel;
   logic             unusedRdata;

   assign idle     = (state == IDLE);
   assign busy     = !idle;
   assign dbgState = state;

   rr_arb2 uArb (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (idle),
      .reqCpu   (cpu_req_valid),
      .reqStrm  (strm_req_valid),
      .update   (cpuAcc || strmAcc),
      .readyCpu (cpu_req_ready),
      .readyStrm(strm_req_ready)
   );

   assign cpuAcc  = cpu_req_valid && cpu_req_ready;
   assign strmAcc = strm_req_valid && strm_req_ready;

   // The memory only ever sees an address registered in this block.
   always_comb begin
      mem_addr = '0;
      case (state)
         CPU_RD:  mem_addr = addrQ;
         BURST:   mem_addr = burstAddr;
         default: mem_addr = '0;
      endcase
   end

   assign rdErr       = ({12'd0, mem_addr} >= PIXELS_TOTAL);
   assign rdPixel     = rdErr ? 8'd0 : mem_rdata[7:0];
   assign unusedRdata = ^mem_rdata[31:8];

   // A new beat may be loaded when the output slot is empty or being drained.
   assign issue = (state == BURST) && (!strm_rsp_valid || strm_rsp_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         addrQ          <= '0;
         burstAddr      <= '0;
         beatCnt        <= '0;
         cpu_rsp_valid  <= 1'b0;
         cpu_rsp_data   <= '0;
         cpu_rsp_err    <= 1'b0;
         strm_rsp_valid <= 1'b0;
         strm_rsp_data  <= '0;
         strm_rsp_err   <= 1'b0;
         strm_rsp_last  <= 1'b0;
      end else begin
         cpu_rsp_valid <= 1'b0;

         // The beat register is independent of state so the final beat keeps
         // holding under backpressure after the FSM has returned to IDLE.
         if (issue) begin
            strm_rsp_valid <= 1'b1;
            strm_rsp_data  <= rdPixel;
            strm_rsp_err   <= rdErr;
            strm_rsp_last  <= (beatCnt == '0);
            burstAddr      <= burstAddr + 20'd1;
            beatCnt        <= beatCnt - LEN_W'(1);
         end else if (strm_rsp_ready) begin
            strm_rsp_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (cpuAcc) begin
                  addrQ <= cpu_req_addr;
                  state <= CPU_RD;
               end else if (strmAcc) begin
                  burstAddr <= strm_req_addr;
                  beatCnt   <= strm_req_len;
                  state     <= BURST;
               end
            end
            CPU_RD: begin
               cpu_rsp_valid <= 1'b1;
               cpu_rsp_data  <= {24'd0, rdPixel};
               cpu_rsp_err   <= rdErr;
               state         <= IDLE;
            end
            BURST: begin
               if (issue && (beatCnt == '0)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb_pixel_mem_arbiter: self-checking bench for pixel_mem_arbiter.
// The memory is a formula of the address; the reference model predicts every
// response from the address rules alone (range check, zero-extension, beat
// count, wrap mod 2^20, round-robin tie rule) and a scoreboard compares.
module tb_pixel_mem_arbiter;

   localparam int PIXELS = 325000;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cpu_req_valid;
   logic [19:0]          cpu_req_addr;
   logic                 cpu_req_ready;
   logic                 cpu_rsp_valid;
   logic [31:0]          cpu_rsp_data;
   logic                 cpu_rsp_err;
   logic                 strm_req_valid;
   logic [19:0]          strm_req_addr;
   logic [3:0]           strm_req_len;
   logic                 strm_req_ready;
   logic                 strm_rsp_valid;
   logic                 strm_rsp_ready;
   logic [7:0]           strm_rsp_data;
   logic                 strm_rsp_err;
   logic                 strm_rsp_last;
   logic [19:0]          mem_addr;
   logic [31:0]          mem_rdata;
   logic                 busy;
   pixel_mem_pkg::stateT dbgState;

   int nCompared   = 0;
   int nMismatched = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   pixel_mem_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpu_req_valid (cpu_req_valid),
      .cpu_req_addr  (cpu_req_addr),
      .cpu_req_ready (cpu_req_ready),
      .cpu_rsp_valid (cpu_rsp_valid),
      .cpu_rsp_data  (cpu_rsp_data),
      .cpu_rsp_err   (cpu_rsp_err),
      .strm_req_valid(strm_req_valid),
      .strm_req_addr (strm_req_addr),
      .strm_req_len  (strm_req_len),
      .strm_req_ready(strm_req_ready),
      .strm_rsp_valid(strm_rsp_valid),
      .strm_rsp_ready(strm_rsp_ready),
      .strm_rsp_data (strm_rsp_data),
      .strm_rsp_err  (strm_rsp_err),
      .strm_rsp_last (strm_rsp_last),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .busy          (busy),
      .dbgState      (dbgState)
   );

   // ---------------- memory and reference model ----------------
   function automatic logic [7:0] memByte(input logic [19:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return 8'(lo * 8'd13 + 8'd102);
   endfunction

   // Upper bits are deliberately non-zero so zero-extension is observable.
   assign mem_rdata = {~mem_addr, mem_addr[3:0], memByte(mem_addr)};

   function automatic logic isErr(input logic [19:0] a);
      return int'({12'd0, a}) >= PIXELS;
   endfunction

   function automatic logic [7:0] expPixel(input logic [19:0] a);
      return isErr(a) ? 8'd0 : memByte(a);
   endfunction

   function automatic logic [9:0] expBeat(input logic [19:0] a, input logic last);
      return {last, isErr(a), expPixel(a)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   logic [32:0] cpuExpQ[$];
   int          cpuCycQ[$];
   logic [9:0]  beatExpQ[$];
   int          sampleIdx     = 0;
   logic        modelLastStrm = 1'b1;
   logic        heldPrev      = 1'b0;
   logic [9:0]  heldBeat;

   always @(negedge clk) begin
      sampleIdx++;
      if (!rst_n) begin
         cpuExpQ.delete();
         cpuCycQ.delete();
         beatExpQ.delete();
         modelLastStrm = 1'b1;
         heldPrev      = 1'b0;
      end else begin
         if (heldPrev) begin
            check("beat_hold_valid", strm_rsp_valid, 1);
            check("beat_hold_value", {strm_rsp_last, strm_rsp_err, strm_rsp_data}, heldBeat);
         end
         heldPrev = strm_rsp_valid && !strm_rsp_ready;
         heldBeat = {strm_rsp_last, strm_rsp_err, strm_rsp_data};

         if (busy)
            check("sb_readies_busy", {cpu_req_ready, strm_req_ready}, 2'b00);
         else if (cpu_req_valid && strm_req_valid)
            check("sb_readies_tie", {cpu_req_ready, strm_req_ready}, modelLastStrm ? 2'b10 : 2'b01);
         else
            check("sb_readies_idle", {cpu_req_ready, strm_req_ready}, 2'b11);

         if (cpu_rsp_valid) begin
            if (cpuExpQ.size() == 0) begin
               check("sb_cpu_unexpected", 1, 0);
            end else begin
               logic [32:0] e;
               int          c;
               e = cpuExpQ.pop_front();
               c = cpuCycQ.pop_front();
               check("sb_cpu_data", cpu_rsp_data, e[31:0]);
               check("sb_cpu_err", cpu_rsp_err, e[32]);
               check("sb_cpu_latency", sampleIdx - c, 2);
            end
         end

         if (strm_rsp_valid && strm_rsp_ready) begin
            if (beatExpQ.size() == 0)
               check("sb_beat_unexpected", 1, 0);
            else
               check("sb_beat", {strm_rsp_last, strm_rsp_err, strm_rsp_data}, beatExpQ.pop_front());
         end

         if (cpu_req_valid && cpu_req_ready) begin
            cpuExpQ.push_back({isErr(cpu_req_addr), 24'd0, expPixel(cpu_req_addr)});
            cpuCycQ.push_back(sampleIdx);
            modelLastStrm = 1'b0;
         end else if (strm_req_valid && strm_req_ready) begin
            for (int i = 0; i <= int'(strm_req_len); i++)
               beatExpQ.push_back(expBeat(strm_req_addr + 20'(i), i == int'(strm_req_len)));
            modelLastStrm = 1'b1;
         end
      end
   end

   // ---------------- stream ready driver ----------------
   int readyMode  = 0;
   int readyPhase = 0;

   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       strm_rsp_ready = 1'b1;
         1: begin
            strm_rsp_ready = (readyPhase % 3 == 0);
            readyPhase++;
         end
         default: strm_rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // ---------------- driver tasks ----------------
   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpuReq(input logic [19:0] a);
      logic done;
      done          = 1'b0;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = a;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = cpu_req_ready;
      end
      check("cpu_req_accepted", done, 1);
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
   endtask

   task automatic strmReq(input logic [19:0] a, input logic [3:0] len);
      logic done;
      done           = 1'b0;
      strm_req_valid = 1'b1;
      strm_req_addr  = a;
      strm_req_len   = len;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = strm_req_ready;
      end
      check("strm_req_accepted", done, 1);
      @(posedge clk);
      #1;
      strm_req_valid = 1'b0;
   endtask

   // Burst with strm_rsp_ready held 1: one beat per cycle after a one-cycle gap.
   task automatic burstCheck(input logic [19:0] a, input logic [3:0] len);
      strmReq(a, len);
      @(negedge clk);
      check("burst_gap", strm_rsp_valid, 0);
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge clk);
         check("burst_valid", strm_rsp_valid, 1);
         check("burst_last", strm_rsp_last, i == int'(len));
         check("burst_err", strm_rsp_err, isErr(a + 20'(i)));
         check("burst_data", strm_rsp_data, expPixel(a + 20'(i)));
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [19:0] randAddr();
      case ($urandom_range(0, 3))
         0:       return 20'($urandom_range(0, PIXELS - 1));
         1:       return 20'(PIXELS - 8 + int'($urandom_range(0, 15)));
         2:       return 20'hFFFF8 + 20'($urandom_range(0, 7));
         default: return 20'($urandom_range(0, 20'hFFFFF));
      endcase
   endfunction

   // ---------------- CPU vector table ----------------
   typedef struct {
      logic [19:0] addr;
      logic [31:0] expData;
      logic        expErr;
   } cpuVecT;

   cpuVecT cpuVec[7];

   // ---------------- test sequence ----------------
   initial begin
      logic done;
      int   cnt;

      cpuVec[0] = '{20'd5,      32'h0000_00A7, 1'b0};
      cpuVec[1] = '{20'd0,      32'h0000_0066, 1'b0};
      cpuVec[2] = '{20'd255,    32'h0000_0059, 1'b0};
      cpuVec[3] = '{20'd65000,  32'h0000_002E, 1'b0};
      cpuVec[4] = '{20'd324999, 32'h0000_0041, 1'b0};
      cpuVec[5] = '{20'd325000, 32'h0000_0000, 1'b1};
      cpuVec[6] = '{20'hFFFFF,  32'h0000_0000, 1'b1};

      rst_n          = 1'b0;
      cpu_req_valid  = 1'b0;
      cpu_req_addr   = '0;
      strm_req_valid = 1'b0;
      strm_req_addr  = '0;
      strm_req_len   = '0;
      strm_rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_rsp_valid", cpu_rsp_valid, 0);
      check("rst_cpu_rsp_data", cpu_rsp_data, 0);
      check("rst_strm_rsp_valid", strm_rsp_valid, 0);
      check("rst_strm_rsp_bits", {strm_rsp_last, strm_rsp_err, strm_rsp_data}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_state", dbgState, pixel_mem_pkg::IDLE);
      check("rst_readies", {cpu_req_ready, strm_req_ready}, 2'b11);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      gap(1);

      // First tie goes to the CPU, the stream follows, then the CPU waits out the burst
      cpu_req_valid  = 1'b1;
      cpu_req_addr   = 20'd10;
      strm_req_valid = 1'b1;
      strm_req_addr  = 20'd100;
      strm_req_len   = 4'd3;
      @(negedge clk);
      check("tie_readies", {cpu_req_ready, strm_req_ready}, 2'b10);
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
      @(negedge clk);
      check("cpu_rd_busy", busy, 1);
      check("cpu_rd_mem_addr", mem_addr, 10);
      check("strm_wait_ready", strm_req_ready, 0);
      check("cpu_rsp_early", cpu_rsp_valid, 0);
      @(negedge clk);
      check("cpu_rsp_valid", cpu_rsp_valid, 1);
      check("cpu_rsp_data", cpu_rsp_data, 32'h0000_00E8);
      check("strm_ready_after_cpu", strm_req_ready, 1);
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b1;
      cpu_req_addr  = 20'd20;
      strm_req_addr = 20'd300;
      strm_req_len  = 4'd0;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("strm_first_gap", strm_rsp_valid, 0);
            check("cpu_rsp_one_cycle", cpu_rsp_valid, 0);
         end else begin
            check("strm_beat_valid", strm_rsp_valid, 1);
            check("strm_beat_last", strm_rsp_last, i == 4);
            check("strm_beat_data", strm_rsp_data, expPixel(20'd99 + 20'(i)));
         end
         check("wait_readies", {cpu_req_ready, strm_req_ready}, (i == 4) ? 2'b10 : 2'b00);
      end
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk);
         done = strm_req_ready;
      end
      check("strm_second_accept", done, 1);
      @(posedge clk);
      #1;
      strm_req_valid = 1'b0;
      gap(4);

      // Single CPU reads from the vector table
      for (int v = 0; v < 7; v++) begin
         cpuReq(cpuVec[v].addr);
         @(negedge clk);
         check("vec_rsp_early", cpu_rsp_valid, 0);
         @(negedge clk);
         check("vec_rsp_valid", cpu_rsp_valid, 1);
         check("vec_rsp_data", cpu_rsp_data, cpuVec[v].expData);
         check("vec_rsp_err", cpu_rsp_err, cpuVec[v].expErr);
         @(posedge clk);
         #1;
      end

      // Bursts across a bank boundary and across the image end
      burstCheck(20'd64998, 4'd3);
      gap(2);
      burstCheck(20'd324998, 4'd3);
      gap(2);

      // 16-beat burst under 1,0,0 backpressure
      readyMode = 1;
      strmReq(20'd1000, 4'd15);
      cnt  = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (strm_rsp_valid && strm_rsp_ready) begin
            cnt++;
            done = strm_rsp_last;
         end
      end
      check("bp_burst_done", done, 1);
      check("bp_beat_count", cnt, 16);
      @(posedge clk);
      #1;
      readyMode = 0;
      gap(3);

      // Reset during beat 5 of a 16-beat burst
      strmReq(20'd2000, 4'd15);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_strm_valid", strm_rsp_valid, 0);
      check("mid_rst_cpu_valid", cpu_rsp_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mem_addr", mem_addr, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_readies", {cpu_req_ready, strm_req_ready}, 2'b11);
      check("post_rst_state", dbgState, pixel_mem_pkg::IDLE);
      check("post_rst_strm_valid", strm_rsp_valid, 0);
      @(posedge clk);
      #1;
      burstCheck(20'd50, 4'd1);
      gap(2);

      // Randomized traffic against the scoreboard
      readyMode = 2;
      fork
         begin
            for (int n = 0; n < 60; n++) begin
               gap($urandom_range(0, 3));
               cpuReq(randAddr());
            end
         end
         begin
            for (int n = 0; n < 40; n++) begin
               gap($urandom_range(0, 4));
               strmReq(randAddr(), 4'($urandom_range(0, 15)));
            end
         end
      join
      readyMode = 0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (cpuExpQ.size() == 0) && (beatExpQ.size() == 0) && !busy;
      end
      check("drain_done", done, 1);
      check("drain_cpu_q", cpuExpQ.size(), 0);
      check("drain_beat_q", beatExpQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
